odometer_seq_ctrl: RTL

Single-clock sequencer that drives one odometer measurement slice through a full cycle: it serially loads the 7-bit control word, fires the measurement trigger, waits for the measurement to complete, then clocks the 10-bit count out of the measurement scan chain. It sits directly upstream and downstream of the odometer measurement/control block: it generates SCAN_IN/SCAN_CLK1/LOAD/MEAS_TRIG/SCAN_CLK2 and consumes MEAS_STRESS and SCAN_OUT. It returns each count to the host as a parallel word with a valid/ready handshake.

---
 rtl/odometer_seq_ctrl.sv | 237 +++++++++++++++++++++++
 1 files changed

// File: rtl/odometer_seq_ctrl.sv
// Sequencer for one odometer measurement slice: serially loads the control word,
// triggers a measurement, waits for it to finish and returns the scanned-out count.
module odometer_seq_ctrl #(
    parameter int CTRL_W  = 7,
    parameter int DATA_W  = 10,
    parameter int DIV     = 4,
    parameter int TIMEOUT = 50000
) (
    input  logic              CLK,
    input  logic              RESETB,
    input  logic              START_REQ,
    input  logic [CTRL_W-1:0] CTRL_WORD,
    output logic              BUSY,
    output logic              SCAN_IN,
    output logic              SCAN_CLK1,
    output logic              LOAD,
    output logic              MEAS_TRIG,
    input  logic              MEAS_STRESS,
    output logic              SCAN_CLK2,
    input  logic              SCAN_OUT,
    output logic [DATA_W-1:0] RESULT,
    output logic              RESULT_VALID,
    input  logic              RESULT_READY,
    output logic              TIMEOUT_ERR
);

    localparam int MAX_W = (CTRL_W > DATA_W) ? CTRL_W : DATA_W;
    localparam int CNT_W = $clog2(MAX_W + 1);
    localparam logic [7:0]       DIV_LAST  = 8'(DIV - 1);
    localparam logic [15:0]      TO_LIMIT  = 16'(TIMEOUT);
    localparam logic [CNT_W-1:0] CTRL_LAST = CNT_W'(CTRL_W - 1);
    localparam logic [CNT_W-1:0] DATA_LAST = CNT_W'(DATA_W - 1);

    typedef enum logic [2:0] {
        IDLE, SHIFT, LOADP, TRIG, WAIT_RISE, WAIT_FALL, READ, HOLD
    } state_t;

    state_t              state, nxt_state;
    logic [7:0]          div_cnt, nxt_div;
    logic [CNT_W-1:0]    bit_cnt, nxt_bit;
    logic                phase_hi, nxt_phase;
    logic [15:0]         wait_cnt, nxt_wait, wait_inc;
    logic [CTRL_W-1:0]   ctrl_sr, nxt_ctrl_sr;
    logic [DATA_W-1:0]   shadow, nxt_shadow;
    logic                stress_meta, stress_sync;
    logic                div_last;
    logic                nxt_busy, nxt_scan_in, nxt_clk1, nxt_load, nxt_trig, nxt_clk2;
    logic                nxt_valid, nxt_err;
    logic [DATA_W-1:0]   nxt_result;

    // MEAS_STRESS comes from the slice's own timing domain, so it is double-flopped.
    always_ff @(posedge CLK or negedge RESETB) begin
        if (!RESETB) begin
            stress_meta <= 1'b0;
            stress_sync <= 1'b0;
        end else begin
            stress_meta <= MEAS_STRESS;
            stress_sync <= stress_meta;
        end
    end

    always_ff @(posedge CLK or negedge RESETB) begin
        if (!RESETB) begin
            state        <= IDLE;
            div_cnt      <= '0;
            bit_cnt      <= '0;
            phase_hi     <= 1'b0;
            wait_cnt     <= '0;
            ctrl_sr      <= '0;
            shadow       <= '0;
            BUSY         <= 1'b0;
            SCAN_IN      <= 1'b0;
            SCAN_CLK1    <= 1'b0;
            LOAD         <= 1'b0;
            MEAS_TRIG    <= 1'b0;
            SCAN_CLK2    <= 1'b0;
            RESULT       <= '0;
            RESULT_VALID <= 1'b0;
            TIMEOUT_ERR  <= 1'b0;
        end else begin
            state        <= nxt_state;
            div_cnt      <= nxt_div;
            bit_cnt      <= nxt_bit;
            phase_hi     <= nxt_phase;
            wait_cnt     <= nxt_wait;
            ctrl_sr      <= nxt_ctrl_sr;
            shadow       <= nxt_shadow;
            BUSY         <= nxt_busy;
            SCAN_IN      <= nxt_scan_in;
            SCAN_CLK1    <= nxt_clk1;
            LOAD         <= nxt_load;
            MEAS_TRIG    <= nxt_trig;
            SCAN_CLK2    <= nxt_clk2;
            RESULT       <= nxt_result;
            RESULT_VALID <= nxt_valid;
            TIMEOUT_ERR  <= nxt_err;
        end
    end

    // Every output is computed here as a next value, so all of them leave the block registered.
    always_comb begin
        nxt_state   = state;
        nxt_div     = div_cnt;
        nxt_bit     = bit_cnt;
        nxt_phase   = phase_hi;
        nxt_wait    = wait_cnt;
        nxt_ctrl_sr = ctrl_sr;
        nxt_shadow  = shadow;
        nxt_scan_in = SCAN_IN;
        nxt_clk1    = SCAN_CLK1;
        nxt_load    = LOAD;
        nxt_trig    = MEAS_TRIG;
        nxt_clk2    = SCAN_CLK2;
        nxt_result  = RESULT;
        nxt_valid   = RESULT_VALID;
        nxt_err     = TIMEOUT_ERR;
        div_last    = (div_cnt == DIV_LAST);
        wait_inc    = (wait_cnt == 16'hFFFF) ? wait_cnt : wait_cnt + 16'd1;

        case (state)
            IDLE: begin
                if (START_REQ) begin
                    nxt_state   = SHIFT;
                    nxt_scan_in = CTRL_WORD[CTRL_W-1];
                    nxt_ctrl_sr = {CTRL_WORD[CTRL_W-2:0], 1'b0};
                    nxt_clk1    = 1'b0;
                    nxt_div     = '0;
                    nxt_bit     = '0;
                    nxt_phase   = 1'b0;
                    nxt_err     = 1'b0;
                end
            end
            SHIFT: begin
                if (!div_last) begin
                    nxt_div = div_cnt + 8'd1;
                end else begin
                    nxt_div = '0;
                    if (!phase_hi) begin
                        nxt_phase = 1'b1;
                        nxt_clk1  = 1'b1;
                    end else if (bit_cnt == CTRL_LAST) begin
                        nxt_clk1  = 1'b0;
                        nxt_load  = 1'b1;
                        nxt_state = LOADP;
                    end else begin
                        nxt_phase   = 1'b0;
                        nxt_clk1    = 1'b0;
                        nxt_bit     = bit_cnt + 1'b1;
                        nxt_scan_in = ctrl_sr[CTRL_W-1];
                        nxt_ctrl_sr = {ctrl_sr[CTRL_W-2:0], 1'b0};
                    end
                end
            end
            LOADP: begin
                if (!div_last) begin
                    nxt_div = div_cnt + 8'd1;
                end else begin
                    nxt_div   = '0;
                    nxt_load  = 1'b0;
                    nxt_trig  = 1'b1;
                    nxt_state = TRIG;
                end
            end
            TRIG: begin
                if (!div_last) begin
                    nxt_div = div_cnt + 8'd1;
                end else begin
                    nxt_div   = '0;
                    nxt_trig  = 1'b0;
                    nxt_wait  = '0;
                    nxt_state = WAIT_RISE;
                end
            end
            WAIT_RISE: begin
                if (stress_sync) begin
                    nxt_wait  = '0;
                    nxt_state = WAIT_FALL;
                end else begin
                    nxt_wait = wait_inc;
                    if (wait_inc == TO_LIMIT) begin
                        nxt_err   = 1'b1;
                        nxt_state = IDLE;
                    end
                end
            end
            WAIT_FALL: begin
                if (!stress_sync) begin
                    nxt_div   = '0;
                    nxt_bit   = '0;
                    nxt_phase = 1'b0;
                    nxt_clk2  = 1'b0;
                    nxt_state = READ;
                end else begin
                    nxt_wait = wait_inc;
                    if (wait_inc == TO_LIMIT) begin
                        nxt_err   = 1'b1;
                        nxt_state = IDLE;
                    end
                end
            end
            READ: begin
                // The chain presents the LSB first, so samples shift in from the top.
                if (!div_last) begin
                    nxt_div = div_cnt + 8'd1;
                end else begin
                    nxt_div = '0;
                    if (!phase_hi) begin
                        nxt_phase = 1'b1;
                        nxt_clk2  = 1'b1;
                    end else begin
                        nxt_shadow = {SCAN_OUT, shadow[DATA_W-1:1]};
                        nxt_phase  = 1'b0;
                        nxt_clk2   = 1'b0;
                        if (bit_cnt == DATA_LAST) begin
                            nxt_state = HOLD;
                        end else begin
                            nxt_bit = bit_cnt + 1'b1;
                        end
                    end
                end
            end
            HOLD: begin
                if (!RESULT_VALID) begin
                    nxt_result = shadow;
                    nxt_valid  = 1'b1;
                end else if (RESULT_READY) begin
                    nxt_valid  = 1'b0;
                    nxt_state  = IDLE;
                end
            end
            default: nxt_state = IDLE;
        endcase

        nxt_busy = (nxt_state != IDLE);
    end

endmodule
